logicnet_lut_layer_pipe: RTL
============================

// Module: logicnet_lut_layer_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-neuron truth-table ROM: NUM_NEURONS LUT neurons evaluated in parallel.
//  Each neuron has its own IN_BITS address and a runtime-loadable OUT_BITS-wide table.
//  Registered outputs behind a 2-entry buffer with valid/ready handshakes; a config FSM drains the pipe before table writes.
//  Sits between gathered-fan-in logic and the next LogicNet layer.
// PARAMETERS
//  NUM_NEURONS  4  neurons (channels) per layer instance
//  IN_BITS      8  address bits per neuron (table depth 2**IN_BITS)
//  OUT_BITS     1  output bits per neuron entry
// PORTS
//  clk          in   1                      clock, rising edge
//  rst_n        in   1                      asynchronous active-low reset
//  in_valid     in   1                      input vector valid
//  in_ready     out  1                      input accepted when in_valid&in_ready
//  in_data      in   NUM_NEURONS*IN_BITS    neuron n address = in_data[n*IN_BITS +: IN_BITS]
//  out_valid    out  1                      output vector valid
//  out_ready    in   1                      downstream accept
//  out_data     out  NUM_NEURONS*OUT_BITS   neuron n result = out_data[n*OUT_BITS +: OUT_BITS]
//  cfg_req      in   1                      request table-load mode; hold high for the whole load session
//  cfg_gnt      out  1                      high while in LOAD; writes honoured only then
//  cfg_we       in   1                      table write strobe
//  cfg_neuron   in   max(1,$clog2(NUM_NEURONS))   target neuron
//  cfg_addr     in   IN_BITS                target entry
//  cfg_wdata    in   OUT_BITS               entry value
//  cfg_re       in   1                      readback strobe (LUT_READBACK_EN only)
//  cfg_rdata    out  OUT_BITS               readback data
// BEHAVIOUR
//  Reset: state=RUN, buffer empty, out_valid=0, out_data=0, cfg_gnt=0, cfg_rdata=0, all table entries=0.
//  Lookup: on accept at edge k, all NUM_NEURONS tables are read combinationally and the results are pushed to the buffer.
//   Latency: out_valid=1 after edge k when the buffer was empty.
//  Buffer: 2-entry FIFO; out_data is always the head entry.
//   in_ready = (state==RUN) && (count<2). This is derived from registered state only, with no out_ready->in_ready path.
//   Push and pop in the same cycle: count unchanged, order preserved.
//   Pop when count==0: impossible, because out_valid=0. Push when count==2: impossible, because in_ready=0.
//   out_data holds stable while out_valid && !out_ready.
//  FSM states:
//   RUN   -> DRAIN when cfg_req=1. in_ready drops the next cycle; a transfer accepted in the same cycle still completes.
//   DRAIN -> LOAD when count==0; out_ready alone empties the buffer.
//   LOAD  -> RUN when cfg_req=0. cfg_gnt=1 only in LOAD; in_ready=0 in DRAIN and LOAD.
//  Write: cfg_we && state==LOAD updates table[cfg_neuron][cfg_addr] at the clock edge.
//   cfg_we outside LOAD is ignored. A cfg_neuron >= NUM_NEURONS is ignored.
//  A write is visible to the first lookup after the return to RUN; no lookup is ever in flight during a write.
//  cfg_req dropped during DRAIN: return to RUN and ignore the request.
//  Reset mid-operation: buffer contents discarded; tables return to 0.
// CONFIGURATION
//  LUT_READBACK_EN defined: cfg_re && state==LOAD registers table[cfg_neuron][cfg_addr] into cfg_rdata at the next edge.
//   cfg_rdata otherwise holds its value.
//  LUT_READBACK_EN undefined: cfg_re ignored, cfg_rdata tied to 0, readback mux not built.
// STRUCTURE
//  logicnet_lut_pkg: FSM state enum (RUN, DRAIN, LOAD) and a clog2 helper function.
//  Sub-module lut_neuron_table (IN_BITS, OUT_BITS): one write port, one combinational read port, one readback port.
//   It has async-reset storage and is instantiated NUM_NEURONS times by a generate loop.
//  Top level holds the FSM, the 2-entry buffer and the write/readback decode.
// TESTING
//  1 Reset, then RUN with defaults: in_data=32'h01_80_FF_00, out_ready=1 -> out_valid next cycle, out_data=4'b0000; in_ready=1.
//  2 Load: cfg_req=1; wait for cfg_gnt; write neuron2 addr 8'h80=1 and neuron0 addr 8'h00=1; cfg_req=0.
//    Then in_data=32'h00_80_00_00 -> out_data=4'b0101.
//  3 Backpressure: out_ready=0, offer 3 vectors -> 2 accepted, in_ready=0.
//    Release out_ready -> both outputs emerge in order, no loss or duplication.
//  4 Drain: raise cfg_req with 2 entries buffered -> cfg_gnt stays 0 until both are popped.
//    cfg_we during DRAIN leaves the table unchanged.
//  5 Assert rst_n=0 mid-stream with 1 entry buffered -> out_valid=0 immediately.
//    Prior table entries read back as 0 after reset.
//  6 LUT_READBACK_EN: write neuron3 addr 8'h5A=1, cfg_re -> cfg_rdata=1 one cycle later.
//    Without the macro, cfg_rdata=0 always.

Source files
------------

// File: rtl/logicnet_lut_pkg.sv
// logicnet_lut_pkg: FSM state encoding and width helper shared by the LUT layer.
package logicnet_lut_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Index width that stays at least one bit wide for single-neuron layers.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/lut_neuron_table.sv
// lut_neuron_table: one neuron's runtime-loadable truth table with async-cleared storage.
// Optional LUT_READBACK_EN adds a second combinational read port for configuration readback.
module lut_neuron_table #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_we,
    input  logic [IN_BITS-1:0]  i_waddr,
    input  logic [OUT_BITS-1:0] i_wdata,
    input  logic [IN_BITS-1:0]  i_raddr,
    output logic [OUT_BITS-1:0] o_rdata
`ifdef LUT_READBACK_EN
    ,
    input  logic [IN_BITS-1:0]  i_rb_addr,
    output logic [OUT_BITS-1:0] o_rb_data
`endif
);

    logic [OUT_BITS-1:0] r_mem [2**IN_BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**IN_BITS; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
`ifdef LUT_READBACK_EN
    assign o_rb_data = r_mem[i_rb_addr];
`endif

endmodule

// File: rtl/logicnet_lut_layer_pipe.sv
// logicnet_lut_layer_pipe: parallel LUT neurons feeding a 2-entry output FIFO, with a drain-then-load config FSM.
// Define LUT_READBACK_EN to build the cfg_re/cfg_rdata table readback path.
module logicnet_lut_layer_pipe
    import logicnet_lut_pkg::*;
#(
    parameter  int NUM_NEURONS = 4,
    parameter  int IN_BITS     = 8,
    parameter  int OUT_BITS    = 1,
    localparam int NW          = clog2_min1(NUM_NEURONS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                            cfg_req,
    output logic                            cfg_gnt,
    input  logic                            cfg_we,
    input  logic [NW-1:0]                   cfg_neuron,
    input  logic [IN_BITS-1:0]              cfg_addr,
    input  logic [OUT_BITS-1:0]             cfg_wdata,
    input  logic                            cfg_re,
    output logic [OUT_BITS-1:0]             cfg_rdata
);

    localparam int OW = NUM_NEURONS * OUT_BITS;

    state_t          r_state;
    state_t          w_next;
    logic [OW-1:0]   r_buf [2];
    logic            r_rd_ptr;
    logic [1:0]      r_cnt;
    logic [OW-1:0]   w_look;
    logic            w_push;
    logic            w_pop;

    assign in_ready  = (r_state == RUN) && (r_cnt != 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign out_data  = r_buf[r_rd_ptr];
    assign cfg_gnt   = (r_state == LOAD);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

`ifdef LUT_READBACK_EN
    logic [OUT_BITS-1:0] w_rb [NUM_NEURONS];
`endif

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
        lut_neuron_table #(
            .IN_BITS  (IN_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_table (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_we      (cfg_gnt && cfg_we && (cfg_neuron == NW'(n))),
            .i_waddr   (cfg_addr),
            .i_wdata   (cfg_wdata),
            .i_raddr   (in_data[n*IN_BITS +: IN_BITS]),
            .o_rdata   (w_look[n*OUT_BITS +: OUT_BITS])
`ifdef LUT_READBACK_EN
            ,
            .i_rb_addr (cfg_addr),
            .o_rb_data (w_rb[n])
`endif
        );
    end

    // Write slot is the one just past the head; a full buffer never pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) r_buf[r_rd_ptr ^ r_cnt[0]] <= w_look;
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_comb begin
        w_next = (r_state == RUN)   ? (cfg_req ? DRAIN : RUN) :
                 (r_state == DRAIN) ? (!cfg_req ? RUN : (r_cnt == 2'd0) ? LOAD : DRAIN) :
                 (r_state == LOAD && cfg_req) ? LOAD : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_next;
    end

`ifdef LUT_READBACK_EN
    logic [OUT_BITS-1:0] r_cfg_rdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cfg_rdata <= '0;
        else if (cfg_gnt && cfg_re && int'(cfg_neuron) < NUM_NEURONS) r_cfg_rdata <= w_rb[cfg_neuron];
    end
    assign cfg_rdata = r_cfg_rdata;
`else
    logic w_unused_re;
    assign w_unused_re = cfg_re;
    assign cfg_rdata   = '0;
`endif

endmodule
